// File: rtl/mspi_pkg.sv
// mspi_pkg: shared constants, the bridge state type and a frame-length
// helper for the Wishbone-to-serial initiator (mspi_wb) and its clock
// generator (mspi_sclk_gen).
package mspi_pkg;

   localparam int ADDR_W     = 24;
   localparam int DATA_W     = 16;
   // start + address + RW (+ write data)
   localparam int CMD_LEN_WR = 42;
   localparam int CMD_LEN_RD = 26;

   typedef enum logic [2:0] {
      IDLE,
      CMD,
      WAIT,
      RDATA,
      RESP,
      DONE
   } state_t;

   // Number of command slots shifted out for an access of the given direction.
   function automatic int cmd_len(input logic we);
      return we ? CMD_LEN_WR : CMD_LEN_RD;
   endfunction

endpackage

// File: rtl/mspi_sclk_gen.sv
// mspi_sclk_gen: serial slot timing for mspi_wb.
// A slot is CLK_DIV cycles with spi_clk low followed by CLK_DIV cycles high.
// While run is low the generator is parked at the start of a low phase,
// so the first cycle with run high is the first low cycle of a slot.
// Ports:
//   clk, rst  system clock, asynchronous active-high reset
//   run       slots are generated while high
//   spi_clk   serial clock (low when idle)
//   fall      first cycle of the low phase
//   rise      first cycle of the high phase
//   sample    last cycle of the high phase (end of slot)
module mspi_sclk_gen
   import mspi_pkg::*;
#(
   parameter int CLK_DIV = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic run,
   output logic spi_clk,
   output logic fall,
   output logic rise,
   output logic sample
);

   localparam int CW = $clog2(2 * CLK_DIV);
   localparam logic [CW-1:0] LAST     = CW'(2 * CLK_DIV - 1);
   localparam logic [CW-1:0] HALF     = CW'(CLK_DIV);
   localparam logic [CW-1:0] PRE_HIGH = CW'(CLK_DIV - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt     <= '0;
         spi_clk <= 1'b0;
      end else if (!run || cnt == LAST) begin
         cnt     <= '0;
         spi_clk <= 1'b0;
      end else begin
         cnt     <= cnt + 1'b1;
         // registered so spi_clk is high exactly while cnt is in the upper half
         spi_clk <= (cnt >= PRE_HIGH);
      end
   end

   assign fall   = run && (cnt == '0);
   assign rise   = run && (cnt == HALF);
   assign sample = run && (cnt == LAST);

endmodule

// File: rtl/mspi_wb.sv
// mspi_wb: classic Wishbone slave that serialises one access at a time
// onto the 4-wire debug/config serial bus as initiator.
// Frame on spi_mosi (LSB first, one bit per slot): start 0, 24 address
// bits, RW (1 = write), 16 write data bits for writes only. Then wait slots
// until the responder drives miso low, 16 read data slots for reads, and
// one response slot carrying the remote error bit.
// Host handshake: a request is wb_cyc & wb_stb seen in IDLE; it is
// acknowledged by exactly one single-cycle pulse of wb_ack (no error) or
// wb_err (remote error or wait timeout). If wb_cyc drops while busy the
// serial frame still runs to completion but the pulse is withheld.
// Ports:
//   i_clk, i_rst          clock, asynchronous active-high reset
//   wb_cyc/stb/we/adr     Wishbone request; wb_sel is ignored
//   wb_i_dat, wb_o_dat    write data in, read data out (held until next read)
//   wb_ack, wb_err        completion pulses
//   spi_clk, spi_mosi     serial clock (idles low), data out (idles high)
//   spi_miso              serial data in, asynchronous, idles high
//   busy                  serial transaction in progress
module mspi_wb
   import mspi_pkg::*;
#(
   parameter int CLK_DIV  = 8,
   parameter int WAIT_MAX = 255
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              wb_cyc,
   input  logic              wb_stb,
   input  logic              wb_we,
   input  logic [ADDR_W-1:0] wb_adr,
   input  logic [DATA_W-1:0] wb_i_dat,
   input  logic [1:0]        wb_sel,
   output logic [DATA_W-1:0] wb_o_dat,
   output logic              wb_ack,
   output logic              wb_err,
   output logic              spi_clk,
   output logic              spi_mosi,
   input  logic              spi_miso,
   output logic              busy
);

   // one slot counter serves command bits, wait slots and read data bits
   localparam int CNT_W = ($clog2(WAIT_MAX) > $clog2(CMD_LEN_WR)) ?
                          $clog2(WAIT_MAX) : $clog2(CMD_LEN_WR);
   localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(WAIT_MAX - 1);
   localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);

   state_t                  state, state_nx;
   logic [CNT_W-1:0]        cnt;
   logic [CMD_LEN_WR-1:0]   frame;
   logic [CMD_LEN_WR-1:0]   sh;
   logic [DATA_W-1:0]       rdata;
   logic                    we_q;
   logic                    abort_q;
   logic [1:0]              miso_sync;
   logic                    miso_s;
   logic                    run;
   logic                    fall, rise, sample;
   logic                    accept, go_done, done_err;
   logic [CNT_W-1:0]        cmd_last;
   logic                    unused_ok;

   assign unused_ok = ^{wb_sel, fall, rise};

   assign frame    = {wb_i_dat, wb_we, wb_adr, 1'b0};
   assign cmd_last = CNT_W'(cmd_len(we_q) - 1);
   assign run      = (state == CMD) || (state == WAIT) ||
                     (state == RDATA) || (state == RESP);

   mspi_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk (
      .clk     (i_clk),
      .rst     (i_rst),
      .run     (run),
      .spi_clk (spi_clk),
      .fall    (fall),
      .rise    (rise),
      .sample  (sample)
   );

   // 2-flop synchroniser; resets to the line's idle level
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) miso_sync <= 2'b11;
      else       miso_sync <= {miso_sync[0], spi_miso};
   end
   assign miso_s = miso_sync[1];

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) state <= IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      accept   = 1'b0;
      go_done  = 1'b0;
      done_err = 1'b0;
      unique case (state)
         IDLE: if (wb_cyc && wb_stb) begin
            accept   = 1'b1;
            state_nx = CMD;
         end
         CMD: if (sample && cnt == cmd_last) state_nx = WAIT;
         WAIT: if (sample) begin
            if (!miso_s) begin
               state_nx = we_q ? RESP : RDATA;
            end else if (cnt == WAIT_LAST) begin
               // responder never answered: give up without further slots
               state_nx = DONE;
               go_done  = 1'b1;
               done_err = 1'b1;
            end
         end
         RDATA: if (sample && cnt == DATA_LAST) state_nx = RESP;
         RESP: if (sample) begin
            state_nx = DONE;
            go_done  = 1'b1;
            done_err = miso_s;
         end
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         cnt      <= '0;
         sh       <= '1;
         rdata    <= '0;
         we_q     <= 1'b0;
         abort_q  <= 1'b0;
         spi_mosi <= 1'b1;
         busy     <= 1'b0;
         wb_ack   <= 1'b0;
         wb_err   <= 1'b0;
         wb_o_dat <= '0;
      end else begin
         wb_ack <= 1'b0;
         wb_err <= 1'b0;

         if (state_nx != state) cnt <= '0;
         else if (sample)       cnt <= cnt + 1'b1;

         if (busy && !wb_cyc) abort_q <= 1'b1;

         if (accept) begin
            // start bit goes out in the first low phase; sh holds the rest
            sh       <= frame >> 1;
            we_q     <= wb_we;
            abort_q  <= 1'b0;
            spi_mosi <= 1'b0;
            busy     <= 1'b1;
         end

         if (state == CMD && sample) begin
            if (cnt == cmd_last) begin
               spi_mosi <= 1'b1;
            end else begin
               spi_mosi <= sh[0];
               sh       <= {1'b1, sh[CMD_LEN_WR-1:1]};
            end
         end

         if (state == RDATA && sample) rdata <= {miso_s, rdata[DATA_W-1:1]};

         if (go_done) begin
            busy <= 1'b0;
            if (state == RESP && !we_q) wb_o_dat <= rdata;
            if (!abort_q && wb_cyc) begin
               wb_ack <= !done_err;
               wb_err <= done_err;
            end
         end
      end
   end

endmodule
